csr_access_unit: RTL and testbench



---
 rtl/csr_access_unit_pkg.sv | 29 ++
 rtl/csr_access_unit_alu.sv | 54 +++++
 rtl/csr_access_unit.sv | 123 ++++++++++++
 tb/tb_csr_access_unit.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/csr_access_unit_pkg.sv
// Shared constants and types for the CSR access unit.
// Holds Zicsr funct3 codes, FSM state encoding and width defaults.
package csr_access_unit_pkg;

  localparam int XLEN_DEF   = 32;
  localparam int CSR_AW_DEF = 12;

  localparam logic [2:0] F3_CSRRW  = 3'b001;
  localparam logic [2:0] F3_CSRRS  = 3'b010;
  localparam logic [2:0] F3_CSRRC  = 3'b011;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  // addr[11:10] of the read-only CSR space
  localparam logic [1:0] RO_PREFIX = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/csr_access_unit_alu.sv
// Combinational read-modify-write for Zicsr: op bits, old, operand
// -> new value, do_write, illegal. Honours CSR_RO_TRAP_EN if defined.
module csr_access_unit_alu
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int CSR_AW = CSR_AW_DEF
) (
  input  logic [1:0]        op_i,
  input  logic [4:0]        rs1_idx_i,
  input  logic [CSR_AW-1:0] addr_i,
  input  logic [XLEN-1:0]   old_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [XLEN-1:0]   new_o,
  output logic              do_write_o,
  output logic              illegal_o
);

  always_comb begin
    new_o      = old_i;
    do_write_o = 1'b0;
    illegal_o  = 1'b0;
    unique case (op_i)
      OP_RW: begin
        new_o      = operand_i;
        do_write_o = 1'b1;
      end
      OP_RS: begin
        new_o      = old_i | operand_i;
        do_write_o = (rs1_idx_i != 5'd0);
      end
      OP_RC: begin
        new_o      = old_i & ~operand_i;
        do_write_o = (rs1_idx_i != 5'd0);
      end
      default: begin
        illegal_o  = 1'b1;
      end
    endcase
`ifdef CSR_RO_TRAP_EN
    // set/clear with x0 only reads, so it stays legal here
    if (do_write_o && addr_i[CSR_AW-1 -: 2] == RO_PREFIX) begin
      illegal_o  = 1'b1;
      do_write_o = 1'b0;
    end
`endif
  end

`ifndef CSR_RO_TRAP_EN
  logic unused_addr;
  assign unused_addr = ^addr_i;
`endif

endmodule

// File: rtl/csr_access_unit.sv
// Zicsr initiator: IDLE -> READ -> [WRITE] -> RESP against a CSR file.
// Ports: req_* in, resp_* out, csr_* to register file. Macro: CSR_RO_TRAP_EN.
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int CSR_AW = CSR_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_funct3,
  input  logic [CSR_AW-1:0] req_csr_addr,
  input  logic [4:0]        req_rs1_idx,
  input  logic [XLEN-1:0]   req_rs1_data,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rd_data,
  output logic              resp_illegal,
  output logic [CSR_AW-1:0] csr_read_addr,
  input  logic [XLEN-1:0]   csr_read_data,
  output logic              csr_write_en,
  output logic [CSR_AW-1:0] csr_write_addr,
  output logic [XLEN-1:0]   csr_write_data
);

  state_e state_q, state_d;

  logic [1:0]        op_q;
  logic [CSR_AW-1:0] addr_q;
  logic [4:0]        idx_q;
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   old_q;
  logic [XLEN-1:0]   new_q;
  logic              ill_q;

  logic [XLEN-1:0]   opnd_d;
  logic [XLEN-1:0]   alu_new;
  logic              alu_wr;
  logic              alu_ill;
  logic              accept;
  logic              unused_f3;

  assign accept = req_valid && (state_q == S_IDLE);

  // funct3[2] selects zimm; only the op bits are kept afterwards
  assign opnd_d = req_funct3[2]
    ? {{(XLEN-5){1'b0}}, req_rs1_idx}
    : req_rs1_data;
  assign unused_f3 = 1'b0;

  csr_access_unit_alu #(
    .XLEN   (XLEN),
    .CSR_AW (CSR_AW)
  ) u_alu (
    .op_i       (op_q),
    .rs1_idx_i  (idx_q),
    .addr_i     (addr_q),
    .old_i      (csr_read_data),
    .operand_i  (opnd_q),
    .new_o      (alu_new),
    .do_write_o (alu_wr),
    .illegal_o  (alu_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_READ;
      S_READ:  state_d = alu_wr ? S_WRITE : S_RESP;
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      addr_q <= '0;
      idx_q  <= '0;
      opnd_q <= '0;
      old_q  <= '0;
      new_q  <= '0;
      ill_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q   <= req_funct3[1:0];
        addr_q <= req_csr_addr;
        idx_q  <= req_rs1_idx;
        opnd_q <= opnd_d;
      end
      // old is taken before any write, so rd sees the pre-write value
      if (state_q == S_READ) begin
        old_q <= csr_read_data;
        new_q <= alu_new;
        ill_q <= alu_ill;
      end
    end
  end

  // addr_q only changes on accept, so the read address holds outside READ
  always_comb begin
    req_ready      = (state_q == S_IDLE);
    resp_valid     = (state_q == S_RESP);
    resp_rd_data   = old_q;
    resp_illegal   = ill_q && (state_q == S_RESP);
    csr_read_addr  = addr_q;
    csr_write_en   = (state_q == S_WRITE);
    csr_write_addr = addr_q;
    csr_write_data = new_q;
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Self-checking bench for csr_access_unit with a CSR file model.
// Random and directed Zicsr requests checked against a reference array.
module tb_csr_access_unit;

  localparam int XLEN   = 32;
  localparam int CSR_AW = 12;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_funct3;
  logic [CSR_AW-1:0] req_csr_addr;
  logic [4:0]        req_rs1_idx;
  logic [XLEN-1:0]   req_rs1_data;
  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rd_data;
  logic              resp_illegal;
  logic [CSR_AW-1:0] csr_read_addr;
  logic [XLEN-1:0]   csr_read_data;
  logic              csr_write_en;
  logic [CSR_AW-1:0] csr_write_addr;
  logic [XLEN-1:0]   csr_write_data;

  logic [XLEN-1:0] rf     [4096];
  logic [XLEN-1:0] ref_rf [4096];
  int wr_cnt;
  int checks;
  int errors;

  csr_access_unit #(.XLEN(XLEN), .CSR_AW(CSR_AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_funct3     (req_funct3),
    .req_csr_addr   (req_csr_addr),
    .req_rs1_idx    (req_rs1_idx),
    .req_rs1_data   (req_rs1_data),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rd_data   (resp_rd_data),
    .resp_illegal   (resp_illegal),
    .csr_read_addr  (csr_read_addr),
    .csr_read_data  (csr_read_data),
    .csr_write_en   (csr_write_en),
    .csr_write_addr (csr_write_addr),
    .csr_write_data (csr_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign csr_read_data = rf[csr_read_addr];

  always @(posedge clk) begin
    if (csr_write_en) begin
      rf[csr_write_addr] <= csr_write_data;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic preset(input logic [11:0] a, input logic [31:0] v);
    rf[a]     = v;
    ref_rf[a] = v;
  endtask

  task automatic run_txn(input logic [2:0] f3, input logic [11:0] a,
                         input logic [4:0] idx, input logic [31:0] d,
                         input int hold);
    logic [31:0] old, op, nv;
    logic        wr, ill;
    int          cyc;
    old = ref_rf[a];
    op  = f3[2] ? {27'd0, idx} : d;
    ill = 1'b0;
    wr  = 1'b0;
    nv  = old;
    case (f3)
      3'b001, 3'b101: begin nv = op;         wr = 1'b1;       end
      3'b010, 3'b110: begin nv = old | op;   wr = (idx != 0); end
      3'b011, 3'b111: begin nv = old & ~op;  wr = (idx != 0); end
      default:        ill = 1'b1;
    endcase
`ifdef CSR_RO_TRAP_EN
    if (wr && a[11:10] == 2'b11) begin
      ill = 1'b1;
      wr  = 1'b0;
    end
`endif
    if (wr) ref_rf[a] = nv;

    @(negedge clk);
    wr_cnt       = 0;
    req_valid    = 1'b1;
    req_funct3   = f3;
    req_csr_addr = a;
    req_rs1_idx  = idx;
    req_rs1_data = d;
    resp_ready   = 1'b0;
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    cyc = 0;
    forever begin
      @(negedge clk);
      req_valid    = 1'b0;
      req_rs1_data = $urandom;
      cyc++;
      if (resp_valid) break;
      if (cyc > 8) break;
    end
    chk("latency", cyc, wr ? 32'd3 : 32'd2);
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("hold_rd", resp_rd_data, old);
      @(negedge clk);
    end
    chk("rd_data", resp_rd_data, old);
    chk("illegal", {31'd0, resp_illegal}, {31'd0, ill});
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_valid", {31'd0, resp_valid}, 32'd0);
    chk("post_ready", {31'd0, req_ready}, 32'd1);
    chk("wr_pulses", wr_cnt, wr ? 32'd1 : 32'd0);
    chk("csr_value", rf[a], ref_rf[a]);
  endtask

  initial begin
    logic [11:0] addrs [5];
    checks       = 0;
    errors       = 0;
    wr_cnt       = 0;
    rst_n        = 1'b0;
    req_valid    = 1'b0;
    req_funct3   = '0;
    req_csr_addr = '0;
    req_rs1_idx  = '0;
    req_rs1_data = '0;
    resp_ready   = 1'b0;
    for (int i = 0; i < 4096; i++) preset(i[11:0], $urandom);
    addrs[0] = 12'h300;
    addrs[1] = 12'h340;
    addrs[2] = 12'h305;
    addrs[3] = 12'hC00;
    addrs[4] = 12'h7C0;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_ill", {31'd0, resp_illegal}, 32'd0);
    chk("rst_rd", resp_rd_data, 32'd0);
    chk("rst_we", {31'd0, csr_write_en}, 32'd0);
    chk("rst_raddr", {20'd0, csr_read_addr}, 32'd0);
    chk("rst_waddr", {20'd0, csr_write_addr}, 32'd0);
    chk("rst_wdata", csr_write_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    preset(12'h340, 32'h11);
    run_txn(3'b001, 12'h340, 5'd7, 32'hDEADBEEF, 0);
    chk("rw_val", rf[12'h340], 32'hDEADBEEF);
    preset(12'h300, 32'h3);
    run_txn(3'b010, 12'h300, 5'd5, 32'h8, 1);
    chk("rs_val", rf[12'h300], 32'hB);
    run_txn(3'b010, 12'h300, 5'd0, 32'h8, 0);
    run_txn(3'b111, 12'h300, 5'd1, 32'hFFFFFFFF, 0);
    chk("rci_val", rf[12'h300], 32'hA);
    run_txn(3'b100, 12'h305, 5'd3, 32'h1234, 5);
    run_txn(3'b000, 12'h305, 5'd3, 32'h1234, 0);
    preset(12'hC00, 32'h55);
    run_txn(3'b001, 12'hC00, 5'd2, 32'hCAFE, 0);
    run_txn(3'b010, 12'hC00, 5'd0, 32'hCAFE, 0);

    // reset while the unit sits in READ
    preset(12'h340, 32'h77);
    @(negedge clk);
    wr_cnt       = 0;
    req_valid    = 1'b1;
    req_funct3   = 3'b001;
    req_csr_addr = 12'h340;
    req_rs1_idx  = 5'd4;
    req_rs1_data = 32'h99;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    chk("mid_rst_we", {31'd0, csr_write_en}, 32'd0);
    chk("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_pulses", wr_cnt, 32'd0);
    chk("mid_rst_csr", rf[12'h340], 32'h77);

    for (int n = 0; n < 60; n++) begin
      logic [4:0] idx;
      idx = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      run_txn(3'($urandom_range(0, 7)), addrs[$urandom_range(0, 4)],
              idx, $urandom, $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
